// File: rtl/bit_serializer_pkg.sv
// -----------------------------------------------------------------------------
// bit_serializer_pkg
//   Shared definitions for the bit_serializer block.
//   - state_t        : shifter state (IDLE, SHIFT)
//   - WIDTH_MIN/MAX  : legal range of the word width parameter
//   - width_legal()  : legality check used at elaboration
//   - frame_bits()   : serial bits per word (word bits plus optional parity)
//   - cnt_width()    : width of the bit counter
//   Optional feature macro: BIT_SERIALIZER_PARITY_EN (appends an even-parity
//   bit after the LSB of every word).
// -----------------------------------------------------------------------------
package bit_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic bit width_legal(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

    // Number of bits presented on the serial line for one word.
    function automatic int frame_bits(input int w);
`ifdef BIT_SERIALIZER_PARITY_EN
        return w + 1;
`else
        return w;
`endif
    endfunction

    // The counter holds frame_bits()-1 down to 0, so it never wraps.
    function automatic int cnt_width(input int w);
`ifdef BIT_SERIALIZER_PARITY_EN
        return $clog2(w + 1);
`else
        return $clog2(w);
`endif
    endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// -----------------------------------------------------------------------------
// bit_serializer_if
//   Groups the word handshake and the serial stream of bit_serializer.
//   Handshake: a word moves on a rising edge where word_valid && word_ready;
//   word_in must be stable while word_valid is high, and the producer may
//   not withdraw a word it has offered until it transfers.
//   Signals:
//     word_in    [WIDTH-1:0] parallel word, MSB sent first
//     word_valid             word_in is valid
//     word_ready             holding register can accept a word
//     bit_out                serial data bit (0 when bit_valid is low)
//     bit_valid              bit_out carries a word or parity bit
//     word_done              pulse while the final bit of a word is out
//     busy                   shifter active or holding register full
//   Modports: master = word producer / stream consumer, slave = serializer.
// -----------------------------------------------------------------------------
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] word_in;
    logic             word_valid;
    logic             word_ready;
    logic             bit_out;
    logic             bit_valid;
    logic             word_done;
    logic             busy;

    modport master (
        output word_in,
        output word_valid,
        input  word_ready,
        input  bit_out,
        input  bit_valid,
        input  word_done,
        input  busy
    );

    modport slave (
        input  word_in,
        input  word_valid,
        output word_ready,
        output bit_out,
        output bit_valid,
        output word_done,
        output busy
    );
endinterface

// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//   Parallel-to-serial front end. Words arrive over a valid/ready handshake
//   into a one-word holding register and leave MSB first, one bit per clock.
//   A word waiting in hold is loaded on the edge after the previous LSB, so
//   back-to-back words stream without idle bits.
//   Ports:
//     clk         rising-edge clock
//     rst         asynchronous, active-high reset
//     bus         bit_serializer_if.slave (handshake + serial stream)
//     o_dbg_state current shifter state
//   Optional feature macro: BIT_SERIALIZER_PARITY_EN -- when defined, an
//   even-parity bit follows the LSB and word_done marks the parity cycle.
// -----------------------------------------------------------------------------
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    bit_serializer_if.slave bus,
    output state_t        o_dbg_state
);

    localparam int SW = frame_bits(WIDTH);
    localparam int CW = cnt_width(WIDTH);

    generate
        if (!width_legal(WIDTH)) begin : g_bad_width
            $error("bit_serializer: WIDTH out of range");
        end
    endgenerate

    state_t          r_state;
    state_t          w_state_nxt;
    logic [WIDTH-1:0] r_hold;
    logic            r_hold_full;
    logic [SW-1:0]   r_shift;
    logic [SW-1:0]   w_shift_nxt;
    logic [SW-1:0]   w_frame;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_load;
    logic            w_last;
    logic            w_accept;
    logic            r_bit_out;
    logic            r_bit_valid;
    logic            r_word_done;
    logic            w_bit_valid_nxt;

    // Ready depends only on the registered hold flag, so hold can never be
    // written while it still holds a word the shifter has not taken.
    assign bus.word_ready = !r_hold_full && !rst;
    assign w_accept       = bus.word_valid && bus.word_ready;
    assign w_last         = (r_cnt == '0);

    // Parity rides along as the last bit of the frame so the shifter and
    // counter treat it exactly like a data bit.
`ifdef BIT_SERIALIZER_PARITY_EN
    assign w_frame = {r_hold, ^r_hold};
`else
    assign w_frame = r_hold;
`endif

    // Holding register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold      <= bus.word_in;
            r_hold_full <= 1'b1;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end
    end

    // Shifter state register and datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_word_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_valid <= w_bit_valid_nxt;
            // Idle line is forced low.
            r_bit_out   <= w_bit_valid_nxt & w_shift_nxt[SW-1];
            r_word_done <= w_bit_valid_nxt && (w_cnt_nxt == '0);
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_hold_full) begin
                    w_load = 1'b1;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    // Reload straight from hold keeps the stream gapless.
                    if (r_hold_full) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_shift_nxt = {r_shift[SW-2:0], 1'b0};
                    w_cnt_nxt   = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (w_load) begin
            w_state_nxt = SHIFT;
            w_shift_nxt = w_frame;
            w_cnt_nxt   = CW'(SW - 1);
        end
        w_bit_valid_nxt = (w_state_nxt == SHIFT);
    end

    assign bus.bit_out   = r_bit_out;
    assign bus.bit_valid = r_bit_valid;
    assign bus.word_done = r_word_done;
    assign bus.busy      = (r_state != IDLE) || r_hold_full;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer
//   Directed self-checking bench for bit_serializer (WIDTH=8). Works in the
//   default build and with BIT_SERIALIZER_PARITY_EN defined.
// -----------------------------------------------------------------------------
module tb_bit_serializer;
    import bit_serializer_pkg::*;

    localparam int WIDTH = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int P = 9;
`else
    localparam int P = 8;
`endif

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_t dbg_state;
    int     cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bit_serializer_if #(.WIDTH(WIDTH)) bus ();

    bit_serializer #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [0:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic push_word(input logic [WIDTH-1:0] w);
        for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(w[i]);
`ifdef BIT_SERIALIZER_PARITY_EN
        exp_q.push_back(^w);
`endif
    endtask

    // Called just after a negedge; returns after the transfer edge, at the
    // following negedge, with word_valid still asserted.
    task automatic drive_word(input logic [WIDTH-1:0] w, output int xfer_cyc);
        int t;
        t = 0;
        bus.word_in    = w;
        bus.word_valid = 1'b1;
        while (bus.word_ready !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (t >= 40) begin
            n_errors++;
            $display("FAIL handshake_timeout word=%h ready=%b required=1", w, bus.word_ready);
        end
        @(posedge clk);
        @(negedge clk);
        xfer_cyc = cyc;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        bus.word_valid = 1'b0;
        bus.word_in = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.word_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready got=%b exp=0", bus.word_ready); end
        n_checks++; if (bus.bit_valid !== 1'b0) begin n_errors++; $display("FAIL reset_bit_valid got=%b exp=0", bus.bit_valid); end
        n_checks++; if (bus.bit_out !== 1'b0) begin n_errors++; $display("FAIL reset_bit_out got=%b exp=0", bus.bit_out); end
        n_checks++; if (bus.word_done !== 1'b0) begin n_errors++; $display("FAIL reset_word_done got=%b exp=0", bus.word_done); end
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_checks++; if (dbg_state !== IDLE) begin n_errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.word_ready !== 1'b1) begin n_errors++; $display("FAIL release_ready got=%b exp=1", bus.word_ready); end
    endtask

    task automatic test_single_word;
        logic [WIDTH-1:0] w;
        logic [2:0] hist;
        logic [0:0] e;
        int n101;
        int xc;
        w = 8'hA5;
        exp_q.delete();
        push_word(w);
        drive_word(w, xc);
        bus.word_valid = 1'b0;
        n_checks++; if (bus.bit_valid !== 1'b0 || bus.busy !== 1'b1) begin n_errors++; $display("FAIL single_after_xfer valid=%b busy=%b exp valid=0 busy=1", bus.bit_valid, bus.busy); end
        hist = '0;
        n101 = 0;
        for (int k = 0; k < P; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++; if (bus.bit_valid !== 1'b1) begin n_errors++; $display("FAIL single_valid bit=%0d got=%b exp=1", k, bus.bit_valid); end
            n_checks++; if (bus.bit_out !== e) begin n_errors++; $display("FAIL single_bit bit=%0d got=%b exp=%b", k, bus.bit_out, e); end
            n_checks++; if (bus.word_done !== (k == P - 1)) begin n_errors++; $display("FAIL single_done bit=%0d got=%b exp=%b", k, bus.word_done, (k == P - 1)); end
            hist = {hist[1:0], bus.bit_out};
            if (k >= 2 && hist == 3'b101) n101++;
        end
        @(negedge clk);
        n_checks++; if (bus.bit_valid !== 1'b0 || bus.bit_out !== 1'b0) begin n_errors++; $display("FAIL single_idle valid=%b out=%b exp 0 0", bus.bit_valid, bus.bit_out); end
        n_checks++; if (dbg_state !== IDLE || bus.busy !== 1'b0) begin n_errors++; $display("FAIL single_state state=%0d busy=%b exp IDLE 0", dbg_state, bus.busy); end
        n_checks++; if (n101 !== 2) begin n_errors++; $display("FAIL single_101_count got=%0d exp=2", n101); end
    endtask

    task automatic test_back_to_back;
        int a, b, t;
        logic [0:0] e;
        exp_q.delete();
        push_word(8'hFF);
        push_word(8'h00);
        fork
            begin
                drive_word(8'hFF, a);
                drive_word(8'h00, b);
                bus.word_valid = 1'b0;
            end
            begin
                t = 0;
                while (bus.bit_valid !== 1'b1 && t < 20) begin @(negedge clk); t++; end
                n_checks++;
                if (t >= 20) begin
                    n_errors++;
                    $display("FAIL b2b_start_timeout got valid=%b exp=1", bus.bit_valid);
                end else begin
                    for (int k = 0; k < 2 * P; k++) begin
                        if (k > 0) @(negedge clk);
                        e = exp_q.pop_front();
                        n_checks++; if (bus.bit_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_valid bit=%0d got=%b exp=1", k, bus.bit_valid); end
                        n_checks++; if (bus.bit_out !== e) begin n_errors++; $display("FAIL b2b_bit bit=%0d got=%b exp=%b", k, bus.bit_out, e); end
                        n_checks++; if (bus.word_done !== ((k % P) == P - 1)) begin n_errors++; $display("FAIL b2b_done bit=%0d got=%b exp=%b", k, bus.word_done, ((k % P) == P - 1)); end
                    end
                end
            end
        join
        @(negedge clk);
        n_checks++; if (bus.bit_valid !== 1'b0 || bus.busy !== 1'b0) begin n_errors++; $display("FAIL b2b_end valid=%b busy=%b exp 0 0", bus.bit_valid, bus.busy); end
    endtask

    task automatic test_backpressure;
        int c0, c1, c2, t;
        logic [0:0] e;
        exp_q.delete();
        push_word(8'h3C);
        push_word(8'h81);
        push_word(8'h5A);
        fork
            begin
                drive_word(8'h3C, c0);
                drive_word(8'h81, c1);
                n_checks++; if (bus.word_ready !== 1'b0) begin n_errors++; $display("FAIL bp_ready_low got=%b exp=0", bus.word_ready); end
                drive_word(8'h5A, c2);
                bus.word_valid = 1'b0;
                n_checks++; if (c1 - c0 !== 2) begin n_errors++; $display("FAIL bp_second_xfer got=%0d exp=2", c1 - c0); end
                n_checks++; if (c2 - c0 !== P + 2) begin n_errors++; $display("FAIL bp_third_xfer got=%0d exp=%0d", c2 - c0, P + 2); end
            end
            begin
                t = 0;
                while (bus.bit_valid !== 1'b1 && t < 20) begin @(negedge clk); t++; end
                n_checks++;
                if (t >= 20) begin
                    n_errors++;
                    $display("FAIL bp_start_timeout got valid=%b exp=1", bus.bit_valid);
                end else begin
                    for (int k = 0; k < 3 * P; k++) begin
                        if (k > 0) @(negedge clk);
                        e = exp_q.pop_front();
                        n_checks++; if (bus.bit_valid !== 1'b1 || bus.bit_out !== e) begin n_errors++; $display("FAIL bp_bit bit=%0d got valid=%b out=%b exp 1 %b", k, bus.bit_valid, bus.bit_out, e); end
                        n_checks++; if (bus.word_done !== ((k % P) == P - 1)) begin n_errors++; $display("FAIL bp_done bit=%0d got=%b exp=%b", k, bus.word_done, ((k % P) == P - 1)); end
                    end
                end
            end
        join
        @(negedge clk);
        n_checks++; if (bus.bit_valid !== 1'b0 || bus.busy !== 1'b0) begin n_errors++; $display("FAIL bp_end valid=%b busy=%b exp 0 0 (extra word)", bus.bit_valid, bus.busy); end
    endtask

    task automatic test_reset_mid_word;
        logic [WIDTH-1:0] w;
        int xc;
        logic bad;
        w = 8'hC3;
        drive_word(w, xc);
        bus.word_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if (bus.bit_valid !== 1'b1 || bus.bit_out !== w[WIDTH-1-k]) begin n_errors++; $display("FAIL rmw_bit bit=%0d got valid=%b out=%b exp 1 %b", k, bus.bit_valid, bus.bit_out, w[WIDTH-1-k]); end
        end
        rst = 1'b1;
        #1;
        n_checks++; if (bus.bit_valid !== 1'b0) begin n_errors++; $display("FAIL rmw_async_valid got=%b exp=0", bus.bit_valid); end
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL rmw_async_busy got=%b exp=0", bus.busy); end
        n_checks++; if (bus.word_ready !== 1'b0 || bus.bit_out !== 1'b0) begin n_errors++; $display("FAIL rmw_async_ready_out ready=%b out=%b exp 0 0", bus.word_ready, bus.bit_out); end
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.bit_out !== 1'b0 || bus.bit_valid !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
        end
        n_checks++; if (bad !== 1'b0) begin n_errors++; $display("FAIL rmw_quiet_after_release got=%b exp=0", bad); end
        n_checks++; if (bus.word_ready !== 1'b1) begin n_errors++; $display("FAIL rmw_ready got=%b exp=1", bus.word_ready); end
    endtask

`ifdef BIT_SERIALIZER_PARITY_EN
    task automatic test_parity;
        logic [17:0] pat;
        int a, b, t;
        pat = 18'b000001111_000000011;
        fork
            begin
                drive_word(8'h07, a);
                drive_word(8'h01, b);
                bus.word_valid = 1'b0;
            end
            begin
                t = 0;
                while (bus.bit_valid !== 1'b1 && t < 20) begin @(negedge clk); t++; end
                n_checks++;
                if (t >= 20) begin
                    n_errors++;
                    $display("FAIL par_start_timeout got valid=%b exp=1", bus.bit_valid);
                end else begin
                    for (int k = 0; k < 18; k++) begin
                        if (k > 0) @(negedge clk);
                        n_checks++; if (bus.bit_valid !== 1'b1 || bus.bit_out !== pat[17-k]) begin n_errors++; $display("FAIL par_bit bit=%0d got valid=%b out=%b exp 1 %b", k, bus.bit_valid, bus.bit_out, pat[17-k]); end
                        n_checks++; if (bus.word_done !== (k == 8 || k == 17)) begin n_errors++; $display("FAIL par_done bit=%0d got=%b exp=%b", k, bus.word_done, (k == 8 || k == 17)); end
                    end
                end
            end
        join
        @(negedge clk);
        n_checks++; if (bus.bit_valid !== 1'b0) begin n_errors++; $display("FAIL par_end valid=%b exp=0", bus.bit_valid); end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        bus.word_in    = '0;
        bus.word_valid = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
`ifdef BIT_SERIALIZER_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
